comparator: RTL and testbench
=============================

Name: comparator

Overview:
- Parameterised W-bit equality/magnitude comparator.
- Provides a zero-latency combinational `equal` flag plus a registered, valid-qualified result path:
  - eq/lt/gt
  - XOR difference mask
  - index of the most-significant differing bit
  - saturating mismatch counter
- Used in datapath checks and self-test logic wherever two W-bit words must be compared, either immediately or as a pipelined event stream.

Parameters:
- W, 16, operand width in bits; legal range 2..64.
- CNT_W, 16, width of the mismatch counter.
- IDX_W, $clog2(W), width of the differing-bit index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  W  operand A.
- b  input  W  operand B.
- signed_mode  input  1  1 = two's-complement magnitude compare, 0 = unsigned.
- in_valid  input  1  samples a/b/signed_mode into the registered path this cycle.
- cnt_clr  input  1  synchronous clear of mismatch_cnt.
- equal  output  1  combinational: 1 iff a == b on all W bits.
- out_valid  output  1  registered result valid, one cycle after in_valid.
- eq_q  output  1  registered a == b.
- lt_q  output  1  registered a < b, per signed_mode.
- gt_q  output  1  registered a > b, per signed_mode.
- diff_mask_q  output  W  registered a ^ b.
- diff_idx_q  output  IDX_W  registered index of the highest set bit of a ^ b; 0 when equal.
- mismatch_cnt  output  CNT_W  count of accepted samples with a != b.

Behaviour:
- `equal` is purely combinational and independent of clk, rst_n and in_valid.
  - Settles within the same delta/timestep as a/b changes.
  - Holds correct values even while rst_n is low.
- Registered path, latency 1:
  - On a rising clk edge with in_valid=1, all *_q outputs load from current a/b/signed_mode and out_valid goes to 1.
  - With in_valid=0, out_valid goes to 0 and the *_q outputs hold their previous values.
- No backpressure; every valid sample is accepted.
- Exactly one of eq_q/lt_q/gt_q is 1 after any accepted sample.
- Signed compare: flip the MSB of both operands, then compare unsigned.
  - Example: a=16'h8000, b=16'h0001, signed → lt_q=1; unsigned → gt_q=1.
- diff_idx_q is a priority encode of a^b, MSB wins; all-zero mask yields 0 (disambiguate with eq_q).
- mismatch_cnt:
  - Increments on each accepted sample with a != b.
  - Saturates at all-ones (no wrap).
  - cnt_clr has priority over increment in the same cycle.
- Reset, asynchronous on rst_n falling:
  - out_valid=0, eq_q=0, lt_q=0, gt_q=0, diff_mask_q=0, diff_idx_q=0, mismatch_cnt=0.
  - Held while rst_n low; in_valid ignored during reset.
  - Reset asserted mid-stream discards the in-flight sample.
  - First accepted sample after deassertion is the first in_valid at a rising edge with rst_n=1.
- X/Z on a/b are not required to be handled beyond normal simulation semantics.

Decomposition:
- Shared package `cmp_pkg`:
  - Default W and CNT_W constants.
  - A typedef for the eq/lt/gt result triple, so downstream blocks decode it identically.
- One sub-module, `msb_priority_enc` (parameter W).
  - Maps a W-bit mask to its highest set bit index plus a `found` flag.
  - Combinational; instantiated on a^b before the output register.
- Everything else (XOR, magnitude compare, counter, output registers) lives in comparator.

Test Plan:
- a=16'h0000, b=16'hAAFF, no clock needed → equal=0 after 10 ns.
  - Then a=b=16'h0022 → equal=1 after 10 ns.
- rst_n=0 then released; in_valid=1 with a=16'h0000, b=16'hAAFF, signed_mode=0 → next edge:
  - out_valid=1, eq_q=0, lt_q=1, gt_q=0.
  - diff_mask_q=16'hAAFF, diff_idx_q=15, mismatch_cnt=1.
- a=16'h8000, b=16'h0001 → signed_mode=1: lt_q=1; signed_mode=0: gt_q=1.
  - Both cases: diff_idx_q=15, equal=0.
- a=b=16'h0022 with in_valid=1 → eq_q=1, diff_mask_q=0, diff_idx_q=0, mismatch_cnt unchanged.
  - Following cycle with in_valid=0 → out_valid=0, *_q held.
- Counter boundaries:
  - CNT_W=4, 20 consecutive mismatching samples → mismatch_cnt saturates at 4'hF.
  - cnt_clr together with a mismatch → mismatch_cnt=0.
- Reset mid-operation: rst_n pulsed low between clk edges while out_valid=1 → all registered outputs 0 immediately (before the next edge); `equal` still tracks a/b.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared constants and the result-triple type for the comparator and its consumers.
package cmp_pkg;

    localparam int CMP_W_DEFAULT     = 16;
    localparam int CMP_CNT_W_DEFAULT = 16;

    // One-hot magnitude result; exactly one field is set after an accepted sample.
    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_res_t;

endpackage

// File: rtl/msb_priority_enc.sv
// Highest-set-bit encoder: index of the MSB that is 1 in mask_i, plus a found flag.
// Combinational, no latency, no backpressure. Index is 0 when the mask is all zero.
module msb_priority_enc #(
    parameter int W     = 16,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Ascending scan, so the last hit (the highest bit) wins.
        for (int i = 0; i < W; i++) begin
            if (mask_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comparator.sv
// W-bit comparator: combinational equal flag plus a registered eq/lt/gt, XOR mask,
// MSB-difference index and saturating mismatch counter. Registered path latency 1.
// No backpressure: every in_valid sample is accepted.
module comparator
    import cmp_pkg::*;
#(
    parameter int  W     = CMP_W_DEFAULT,
    parameter int  CNT_W = CMP_CNT_W_DEFAULT,
    localparam int IDX_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             signed_mode,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             equal,
    output logic             out_valid,
    output logic             eq_q,
    output logic             lt_q,
    output logic             gt_q,
    output logic [W-1:0]     diff_mask_q,
    output logic [IDX_W-1:0] diff_idx_q,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic [W-1:0]     diff_d;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_found;
    cmp_res_t         res_d;
    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] cnt_d;

    logic             valid_q;
    cmp_res_t         res_q;
    logic [W-1:0]     mask_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;

    assign equal  = (a == b);
    assign diff_d = a ^ b;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign a_mag = signed_mode ? {~a[W-1], a[W-2:0]} : a;
    assign b_mag = signed_mode ? {~b[W-1], b[W-2:0]} : b;

    always_comb begin
        res_d    = '0;
        res_d.eq = equal;
        res_d.lt = (a_mag < b_mag);
        res_d.gt = (a_mag > b_mag);
    end

    msb_priority_enc #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_enc (
        .mask_i  (diff_d),
        .idx_o   (enc_idx),
        .found_o (enc_found)
    );

    assign idx_d = enc_found ? enc_idx : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && !equal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= in_valid;
            cnt_q   <= cnt_d;
            if (in_valid) begin
                res_q  <= res_d;
                mask_q <= diff_d;
                idx_q  <= idx_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign eq_q         = res_q.eq;
    assign lt_q         = res_q.lt;
    assign gt_q         = res_q.gt;
    assign diff_mask_q  = mask_q;
    assign diff_idx_q   = idx_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator: vector table plus reset, hold and counter sequences.
module tb_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        equal, out_valid, eq_q, lt_q, gt_q;
    logic [15:0] diff_mask_q;
    logic [3:0]  diff_idx_q;
    logic [15:0] mismatch_cnt;

    logic        equal4, out_valid4, eq_q4, lt_q4, gt_q4;
    logic [15:0] diff_mask_q4;
    logic [3:0]  diff_idx_q4;
    logic [3:0]  mismatch_cnt4;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    comparator #(.W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .signed_mode(signed_mode),
        .in_valid(in_valid), .cnt_clr(cnt_clr), .equal(equal),
        .out_valid(out_valid), .eq_q(eq_q), .lt_q(lt_q), .gt_q(gt_q),
        .diff_mask_q(diff_mask_q), .diff_idx_q(diff_idx_q),
        .mismatch_cnt(mismatch_cnt)
    );

    comparator #(.W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .signed_mode(signed_mode),
        .in_valid(in_valid), .cnt_clr(cnt_clr), .equal(equal4),
        .out_valid(out_valid4), .eq_q(eq_q4), .lt_q(lt_q4), .gt_q(gt_q4),
        .diff_mask_q(diff_mask_q4), .diff_idx_q(diff_idx_q4),
        .mismatch_cnt(mismatch_cnt4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic        eq;
        logic        lt;
        logic        gt;
        logic [15:0] mask;
        logic [3:0]  idx;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 ns after the following rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic sm, input logic vld, input logic clr);
        @(negedge clk);
        a = va;
        b = vb;
        signed_mode = sm;
        in_valid = vld;
        cnt_clr = clr;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " eq/lt/gt"}, 64'({eq_q, lt_q, gt_q}), 64'd0);
        check({tag, " diff_mask"}, 64'(diff_mask_q), 64'd0);
        check({tag, " diff_idx"}, 64'(diff_idx_q), 64'd0);
        check({tag, " mismatch_cnt"}, 64'(mismatch_cnt), 64'd0);
        check({tag, " mismatch_cnt4"}, 64'(mismatch_cnt4), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;
        int exp_cnt4;

        tbl[0] = '{16'h0000, 16'hAAFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAAFF, 4'd15};
        tbl[1] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 4'd15};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 4'd15};
        tbl[3] = '{16'h0022, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[4] = '{16'h0010, 16'h0013, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 4'd1};
        tbl[5] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 4'd15};
        tbl[6] = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 4'd15};
        tbl[7] = '{16'h0100, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 4'd8};
        tbl[8] = '{16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd0};

        // Combinational equal with no clock edge involvement, during reset.
        #2 rst_n = 1'b0;
        a = 16'h0000; b = 16'hAAFF;
        #10 check("equal comb ne", 64'(equal), 64'd0);
        a = 16'h0022; b = 16'h0022;
        #10 check("equal comb eq", 64'(equal), 64'd1);

        // in_valid is ignored while reset is held.
        in_valid = 1'b1;
        a = 16'h1234; b = 16'h0000;
        step();
        check_regs_zero("reset");

        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        exp_cnt = 0;
        exp_cnt4 = 0;
        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].sm, 1'b1, 1'b0);
            #1 check($sformatf("v%0d equal", i), 64'(equal), 64'(tbl[i].eq));
            if (tbl[i].a != tbl[i].b) begin
                exp_cnt++;
                exp_cnt4 = (exp_cnt4 == 15) ? 15 : exp_cnt4 + 1;
            end
            step();
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d eq/lt/gt", i), 64'({eq_q, lt_q, gt_q}),
                  64'({tbl[i].eq, tbl[i].lt, tbl[i].gt}));
            check($sformatf("v%0d diff_mask", i), 64'(diff_mask_q), 64'(tbl[i].mask));
            check($sformatf("v%0d diff_idx", i), 64'(diff_idx_q), 64'(tbl[i].idx));
            check($sformatf("v%0d mismatch_cnt", i), 64'(mismatch_cnt), 64'(exp_cnt));
        end

        // Equal sample then an idle cycle: outputs hold, out_valid drops.
        drive(16'h0022, 16'h0022, 1'b0, 1'b1, 1'b0);
        step();
        drive(16'h5555, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        check("hold out_valid", 64'(out_valid), 64'd0);
        check("hold eq/lt/gt", 64'({eq_q, lt_q, gt_q}), 64'b100);
        check("hold diff_mask", 64'(diff_mask_q), 64'd0);
        check("hold diff_idx", 64'(diff_idx_q), 64'd0);
        check("hold mismatch_cnt", 64'(mismatch_cnt), 64'(exp_cnt));
        check("cnt4 before sat", 64'(mismatch_cnt4), 64'(exp_cnt4));

        // Clear alone, then 20 mismatches: the 4-bit counter pins at F.
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        check("clr mismatch_cnt", 64'(mismatch_cnt), 64'd0);
        for (int k = 0; k < 20; k++) begin
            drive(16'(k + 1), 16'h0000, 1'b0, 1'b1, 1'b0);
            step();
        end
        check("sat mismatch_cnt4", 64'(mismatch_cnt4), 64'hF);
        check("sat mismatch_cnt16", 64'(mismatch_cnt), 64'd20);

        // Clear wins over a simultaneous mismatch.
        drive(16'h00F0, 16'h000F, 1'b0, 1'b1, 1'b1);
        step();
        check("clr+inc cnt", 64'(mismatch_cnt), 64'd0);
        check("clr+inc cnt4", 64'(mismatch_cnt4), 64'd0);
        check("clr+inc gt", 64'(gt_q), 64'd1);
        drive(16'h00F0, 16'h000F, 1'b0, 1'b1, 1'b0);
        step();
        check("post-clr cnt", 64'(mismatch_cnt), 64'd1);

        // Asynchronous reset between edges while out_valid is high.
        check("pre-rst out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_regs_zero("mid-rst");
        a = 16'hBEEF; b = 16'hBEEF;
        #1 check("mid-rst equal", 64'(equal), 64'd1);
        b = 16'hBEEE;
        #1 check("mid-rst equal ne", 64'(equal), 64'd0);
        step();
        check("rst held out_valid", 64'(out_valid), 64'd0);
        check("rst held cnt", 64'(mismatch_cnt), 64'd0);

        // First sample after release is accepted normally.
        drive(16'h0003, 16'h0002, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();
        check("post-rst out_valid", 64'(out_valid), 64'd1);
        check("post-rst gt", 64'({eq_q, lt_q, gt_q}), 64'b001);
        check("post-rst idx", 64'(diff_idx_q), 64'd0);
        check("post-rst cnt", 64'(mismatch_cnt), 64'd1);

        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
